// File: rtl/dft_mag2.sv
// dft_mag2: squared magnitude re^2+im^2 using two serial shift-add squarings, then waits for the dft_sqrt done edge.
// Optional one-entry input holding buffer: define DFT_MAG2_BUF_EN.
module dft_mag2 #(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     re_in,
  input  logic [DATA_W-1:0]     im_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [2*DATA_W-1:0]   sq_data,
  output logic                  sq_valid,
  input  logic                  sq_done,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam int P_W   = 2 * DATA_W;

  typedef enum logic [2:0] {IDLE, ABS, MUL_RE, MUL_IM, SEND, WAIT} state_t;

  state_t            state;
  logic [DATA_W-1:0] re_r, im_r, abs_im, mplier;
  logic [P_W-1:0]    mcand, acc, addend;
  logic [CNT_W-1:0]  cnt;
  logic              done_q, done_rise, last_bit, load;
  logic [DATA_W-1:0] load_re, load_im;

  // Two's complement magnitude; the most negative value maps to 2^(DATA_W-1) as unsigned.
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? ((~x) + DATA_W'(1)) : x;
  endfunction

`ifdef DFT_MAG2_BUF_EN
  logic              buf_vld;
  logic [DATA_W-1:0] buf_re, buf_im;
  logic              take;

  assign in_ready = !rst && !buf_vld;
  assign take     = in_valid && in_ready;
  // An idle core drains the buffer first; a fresh pair bypasses only when the buffer is empty.
  assign load     = (state == IDLE) && (buf_vld || take);
  assign load_re  = buf_vld ? buf_re : re_in;
  assign load_im  = buf_vld ? buf_im : im_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_vld <= 1'b0;
      buf_re  <= '0;
      buf_im  <= '0;
    end else if (take && (state != IDLE)) begin
      buf_vld <= 1'b1;
      buf_re  <= re_in;
      buf_im  <= im_in;
    end else if (state == IDLE) begin
      buf_vld <= 1'b0;
    end
  end
`else
  assign in_ready = !rst && (state == IDLE);
  assign load     = in_valid && in_ready;
  assign load_re  = re_in;
  assign load_im  = im_in;
`endif

  assign done_rise = sq_done && !done_q;
  assign last_bit  = (cnt == CNT_W'(DATA_W - 1));
  assign addend    = mplier[0] ? mcand : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sq_valid <= 1'b0;
      sq_data  <= '0;
      acc      <= '0;
      done_q   <= 1'b0;
      re_r     <= '0;
      im_r     <= '0;
      abs_im   <= '0;
      mplier   <= '0;
      mcand    <= '0;
      cnt      <= '0;
    end else begin
      done_q   <= sq_done;
      sq_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            re_r  <= load_re;
            im_r  <= load_im;
            state <= ABS;
          end
        end
        ABS: begin
          mcand  <= P_W'(abs_val(re_r));
          mplier <= abs_val(re_r);
          abs_im <= abs_val(im_r);
          acc    <= '0;
          cnt    <= '0;
          state  <= MUL_RE;
        end
        MUL_RE, MUL_IM: begin
          // One multiplier bit per cycle; im^2 accumulates on top of re^2.
          acc    <= acc + addend;
          cnt    <= cnt + CNT_W'(1);
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (last_bit) begin
            cnt <= '0;
            if (state == MUL_RE) begin
              mcand  <= P_W'(abs_im);
              mplier <= abs_im;
              state  <= MUL_IM;
            end else begin
              sq_data  <= acc + addend;
              sq_valid <= 1'b1;
              state    <= SEND;
            end
          end
        end
        SEND: state <= WAIT;
        WAIT: begin
          if (done_rise) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
